// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, valid/frame_err pulses.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;
  logic          perr_q, perr_d;
  logic          rx_meta_q, rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        perr_d = 1'b0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = rx_s_q ^ (^shift_q);
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            fe_d    = 1'b1;
            state_d = BRK;
          end else if (perr_q) begin
            fe_d    = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes/errors queued per frame,
// checked by a negedge monitor whenever a pulse appears.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  typedef struct packed {
    logic       fe;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         passed = 0;
  int         pulses = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (data_valid || frame_err)) begin
      pulses++;
      checks++;
      if (data_valid && frame_err) begin
        $display("FAIL both_high data_valid=1 frame_err=1 data=%h", data);
      end else if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse dv=%0b fe=%0b data=%h",
                 data_valid, frame_err, data);
      end else begin
        e = sb.pop_front();
        if ({frame_err, data} !== {e.fe, e.d})
          $display("FAIL scoreboard got fe=%0b data=%h want fe=%0b data=%h",
                   frame_err, data, e.fe, e.d);
        else
          passed++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("unreachable parity %b", par);
`endif
    send_bit(stop);
  endtask

  task automatic send_byte(input logic [7:0] b);
    sb.push_back('{fe: 1'b0, d: b});
    last_good = b;
    send_frame(b, ^b, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL drain_%s pending=%0d want 0", name, sb.size());
      sb.delete();
    end else begin
      passed++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want)
      $display("FAIL %s got=%h want=%h", name, got, want);
    else
      passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    checks++;
    if ({data, data_valid, frame_err, busy} !== 11'h0)
      $display("FAIL reset_outputs got=%h want=000", {data, data_valid, frame_err, busy});
    else
      passed++;
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int p0;
    p0 = pulses;
    send_byte(8'h48);
    wait_drain("single");
    tick(2);
    chk("single_data", 32'(data), 32'h48);
    chk("single_busy", 32'(busy), 32'h0);
    chk("single_pulses", 32'(pulses - p0), 32'd1);
  endtask

  task automatic test_back_to_back;
    string msg;
    int    p0;
    msg = "Hello World!\n";
    p0  = pulses;
    for (int i = 0; i < msg.len(); i++) send_byte(msg[i]);
    wait_drain("b2b");
    chk("b2b_pulses", 32'(pulses - p0), 32'd13);
    chk("b2b_last", 32'(data), 32'h0A);
  endtask

  task automatic test_glitch;
    int p0;
    p0 = pulses;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    chk("glitch_busy", 32'(busy), 32'h0);
    chk("glitch_pulses", 32'(pulses - p0), 32'd0);
    send_byte(8'hA5);
    wait_drain("glitch");
    chk("glitch_data", 32'(data), 32'hA5);
  endtask

  task automatic test_break;
    sb.push_back('{fe: 1'b1, d: last_good});
    send_frame(8'h55, ^8'h55, 1'b0);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(16);
    wait_drain("break");
    chk("break_data_kept", 32'(data), 32'hA5);
    chk("break_busy", 32'(busy), 32'h0);
    send_byte(8'h3C);
    wait_drain("after_break");
    chk("after_break_data", 32'(data), 32'h3C);
  endtask

  task automatic test_reset_mid;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + CPB / 2);
    rst = 1'b1;
    tick(2);
    checks++;
    if ({data, data_valid, frame_err, busy} !== 11'h0)
      $display("FAIL midreset_outputs got=%h want=000", {data, data_valid, frame_err, busy});
    else
      passed++;
    last_good = 8'h00;
    rst = 1'b0;
    tick(20);
    chk("midreset_idle", 32'(busy), 32'h0);
    send_byte(8'h12);
    wait_drain("midreset");
    chk("midreset_data", 32'(data), 32'h12);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_byte(8'h48);
    wait_drain("parity_good");
    sb.push_back('{fe: 1'b1, d: 8'h48});
    send_frame(8'h48, 1'b1, 1'b1);
    wait_drain("parity_bad");
    chk("parity_data_kept", 32'(data), 32'h48);
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    tick(10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
